gnr_node_mc: RTL and testbench

//  Multi-channel, parametrised Boolean-network node for the GRN simulator.

---
 rtl/gnr_node_pkg.sv | 19 +
 rtl/gnr_node_ch.sv | 100 ++++++++++
 rtl/gnr_node_mc.sv | 48 ++++
 tb/tb_gnr_node_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_node_pkg.sv
// Shared defaults and helpers for the multi-channel GRN node (gnr_node_mc).
package gnr_node_pkg;

    localparam int unsigned DIV_W_DEF   = 4;
    localparam int unsigned STAB_W_DEF  = 8;
    localparam int unsigned STAB_TH_DEF = 16;
    localparam int unsigned TRANS_CNT_W = 16;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    // A divide ratio of zero is meaningless; treat it as "update every start".
    function automatic logic [31:0] div_coerce(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/gnr_node_ch.sv
// One GRN node channel: state register, update divider, no-change run counter and strobes.
// Optional per-channel transition counter when GNR_NODE_TRACE_EN is defined.
module gnr_node_ch
    import gnr_node_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned STAB_W  = STAB_W_DEF,
    parameter int unsigned STAB_TH = STAB_TH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reset_nos,
    input  logic [WIDTH-1:0]       init_state,
    input  logic [DIV_W-1:0]       div_cfg,
    input  logic                   start,
    input  logic [WIDTH-1:0]       next_s,
    output logic [WIDTH-1:0]       s,
    output logic                   upd,
    output logic                   chg,
    output logic                   stable,
    output logic [TRANS_CNT_W-1:0] trans_cnt
);

    localparam logic [31:0] RUN_MAX = (32'd1 << STAB_W) - 32'd1;
    localparam logic [31:0] TRC_MAX = (32'd1 << TRANS_CNT_W) - 32'd1;

    logic [DIV_W-1:0]  cnt, cnt_nx;
    logic [DIV_W-1:0]  div_r, div_nx;
    logic [STAB_W-1:0] run, run_nx;
    logic [WIDTH-1:0]  s_nx;
    logic              upd_nx, chg_nx, stable_nx;

    // Priority: reset_nos over start; a start landing on cnt==0 commits next_s.
    always_comb begin
        s_nx      = s;
        cnt_nx    = cnt;
        div_nx    = div_r;
        run_nx    = run;
        upd_nx    = 1'b0;
        chg_nx    = 1'b0;
        stable_nx = stable;
        if (reset_nos) begin
            s_nx      = init_state;
            cnt_nx    = '0;
            div_nx    = DIV_W'(div_coerce(32'(div_cfg)));
            run_nx    = '0;
            stable_nx = 1'b0;
        end else if (start) begin
            if (cnt == '0) begin
                s_nx      = next_s;
                cnt_nx    = div_r - DIV_W'(1);
                upd_nx    = 1'b1;
                chg_nx    = (next_s != s);
                run_nx    = chg_nx ? '0 : STAB_W'(sat_inc(32'(run), RUN_MAX));
                stable_nx = (32'(run_nx) >= 32'(STAB_TH));
            end else begin
                cnt_nx = cnt - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= '0;
            cnt    <= '0;
            div_r  <= DIV_W'(1);
            run    <= '0;
            upd    <= 1'b0;
            chg    <= 1'b0;
            stable <= 1'b0;
        end else begin
            s      <= s_nx;
            cnt    <= cnt_nx;
            div_r  <= div_nx;
            run    <= run_nx;
            upd    <= upd_nx;
            chg    <= chg_nx;
            stable <= stable_nx;
        end
    end

`ifdef GNR_NODE_TRACE_EN
    // Transition counter survives reset_nos; only rst clears it.
    logic [TRANS_CNT_W-1:0] trc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            trc_r <= '0;
        end else if (chg_nx) begin
            trc_r <= TRANS_CNT_W'(sat_inc(32'(trc_r), TRC_MAX));
        end
    end

    assign trans_cnt = trc_r;
`else
    assign trans_cnt = '0;
`endif

endmodule

// File: rtl/gnr_node_mc.sv
// Multi-channel GRN Boolean-network node: NCH independent gnr_node_ch instances on flat buses.
// Define GNR_NODE_TRACE_EN to enable per-channel transition counters on trans_cnt.
module gnr_node_mc
    import gnr_node_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned STAB_W  = STAB_W_DEF,
    parameter int unsigned STAB_TH = STAB_TH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reset_nos,
    input  logic [WIDTH-1:0]           init_state,
    input  logic [NCH*DIV_W-1:0]       div_cfg,
    input  logic [NCH-1:0]             start,
    input  logic [NCH*WIDTH-1:0]       next_s,
    output logic [NCH*WIDTH-1:0]       s,
    output logic [NCH-1:0]             upd,
    output logic [NCH-1:0]             chg,
    output logic [NCH-1:0]             stable,
    output logic [NCH*TRANS_CNT_W-1:0] trans_cnt
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gnr_node_ch #(
            .WIDTH  (WIDTH),
            .DIV_W  (DIV_W),
            .STAB_W (STAB_W),
            .STAB_TH(STAB_TH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .reset_nos (reset_nos),
            .init_state(init_state),
            .div_cfg   (div_cfg[c*DIV_W +: DIV_W]),
            .start     (start[c]),
            .next_s    (next_s[c*WIDTH +: WIDTH]),
            .s         (s[c*WIDTH +: WIDTH]),
            .upd       (upd[c]),
            .chg       (chg[c]),
            .stable    (stable[c]),
            .trans_cnt (trans_cnt[c*TRANS_CNT_W +: TRANS_CNT_W])
        );
    end

endmodule

// File: tb/tb_gnr_node_mc.sv
// Directed self-checking bench for gnr_node_mc (NCH=2, WIDTH=1, DIV_W=4, STAB_TH=16).
module tb_gnr_node_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        reset_nos;
    logic [0:0]  init_state;
    logic [7:0]  div_cfg;
    logic [1:0]  start;
    logic [1:0]  next_s;
    logic [1:0]  s;
    logic [1:0]  upd;
    logic [1:0]  chg;
    logic [1:0]  stable;
    logic [31:0] trans_cnt;

    int checks   = 0;
    int failures = 0;

    gnr_node_mc dut (
        .clk       (clk),
        .rst       (rst),
        .reset_nos (reset_nos),
        .init_state(init_state),
        .div_cfg   (div_cfg),
        .start     (start),
        .next_s    (next_s),
        .s         (s),
        .upd       (upd),
        .chg       (chg),
        .stable    (stable),
        .trans_cnt (trans_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reinit(input logic init, input logic [3:0] d0, input logic [3:0] d1);
        init_state = init;
        div_cfg    = {d1, d0};
        reset_nos  = 1'b1;
        tick();
        reset_nos  = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] mask, input logic [1:0] ns);
        start  = mask;
        next_s = ns;
        tick();
        start  = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; reset_nos = 1'b0; init_state = 1'b0; div_cfg = '0;
        start = 2'b00; next_s = 2'b00;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({s, upd, chg, stable} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got s=%b upd=%b chg=%b stable=%b want all 0", s, upd, chg, stable);
        end
        checks++;
        if (trans_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_trans got %h want 0", trans_cnt);
        end
    endtask

    task automatic test_div2();
        logic [1:0] exp_s;
        int n_upd, n_chg;
        n_upd = 0; n_chg = 0;
        reinit(1'b1, 4'd2, 4'd2);
        exp_s = 2'b11;
        checks++;
        if (s !== exp_s) begin
            failures++;
            $display("FAIL div2_init got %b want %b", s, exp_s);
        end
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ns, exp_upd;
            ns = ~exp_s;
            do_start(2'b11, ns);
            exp_upd = (k % 2 == 0) ? 2'b11 : 2'b00;
            if (k % 2 == 0) exp_s = ns;
            n_upd += int'(upd[0]);
            n_chg += int'(chg[0]);
            checks++;
            if (upd !== exp_upd || s !== exp_s) begin
                failures++;
                $display("FAIL div2_start%0d got upd=%b s=%b want upd=%b s=%b", k, upd, s, exp_upd, exp_s);
            end
        end
        checks++;
        if (n_upd != 2 || n_chg != 2) begin
            failures++;
            $display("FAIL div2_counts got upd=%0d chg=%0d want 2 2", n_upd, n_chg);
        end
        tick();
        checks++;
        if (upd !== 2'b00 || chg !== 2'b00 || s !== 2'b11) begin
            failures++;
            $display("FAIL div2_idle got upd=%b chg=%b s=%b want 00 00 11", upd, chg, s);
        end
    endtask

    task automatic test_div_coerce();
        logic [1:0] exp_s;
        reinit(1'b0, 4'd0, 4'd1);
        exp_s = 2'b00;
        for (int k = 0; k < 3; k++) begin
            exp_s = ~exp_s;
            do_start(2'b11, exp_s);
            checks++;
            if (upd !== 2'b11 || chg !== 2'b11 || s !== exp_s) begin
                failures++;
                $display("FAIL coerce_start%0d got upd=%b chg=%b s=%b want 11 11 %b", k, upd, chg, s, exp_s);
            end
        end
    endtask

    task automatic test_reinit_vs_start();
        init_state = 1'b1;
        div_cfg    = {4'd2, 4'd2};
        reset_nos  = 1'b1;
        start      = 2'b11;
        next_s     = 2'b00;
        tick();
        reset_nos = 1'b0;
        start     = 2'b00;
        checks++;
        if (s !== 2'b11 || upd !== 2'b00) begin
            failures++;
            $display("FAIL reinit_prio got s=%b upd=%b want 11 00", s, upd);
        end
        do_start(2'b11, 2'b00);
        checks++;
        if (s !== 2'b00 || upd !== 2'b11) begin
            failures++;
            $display("FAIL reinit_next got s=%b upd=%b want 00 11", s, upd);
        end
    endtask

    task automatic test_stable();
        reinit(1'b0, 4'd1, 4'd1);
        for (int k = 0; k < 15; k++) do_start(2'b11, 2'b00);
        tick();
        checks++;
        if (stable !== 2'b00) begin
            failures++;
            $display("FAIL stab_15 got %b want 00", stable);
        end
        do_start(2'b11, 2'b00);
        checks++;
        if (chg !== 2'b00 || upd !== 2'b11) begin
            failures++;
            $display("FAIL stab_16_strobe got upd=%b chg=%b want 11 00", upd, chg);
        end
        tick();
        checks++;
        if (stable !== 2'b11) begin
            failures++;
            $display("FAIL stab_16 got %b want 11", stable);
        end
        do_start(2'b11, 2'b01);
        checks++;
        if (chg !== 2'b01 || upd !== 2'b11) begin
            failures++;
            $display("FAIL stab_chg got upd=%b chg=%b want 11 01", upd, chg);
        end
        tick();
        checks++;
        if (stable !== 2'b10) begin
            failures++;
            $display("FAIL stab_drop got %b want 10", stable);
        end
        do_start(2'b11, 2'b01);
        tick();
        checks++;
        if (stable !== 2'b10) begin
            failures++;
            $display("FAIL stab_rerun got %b want 10", stable);
        end
    endtask

    task automatic test_rst_mid_divide();
        reinit(1'b0, 4'd3, 4'd3);
        do_start(2'b11, 2'b11);
        checks++;
        if (upd !== 2'b11 || s !== 2'b11) begin
            failures++;
            $display("FAIL div3_first got upd=%b s=%b want 11 11", upd, s);
        end
        do_start(2'b11, 2'b00);
        checks++;
        if (upd !== 2'b00 || s !== 2'b11) begin
            failures++;
            $display("FAIL div3_second got upd=%b s=%b want 00 11", upd, s);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (s !== 2'b00 || upd !== 2'b00 || stable !== 2'b00) begin
            failures++;
            $display("FAIL div3_rst got s=%b upd=%b stable=%b want 00 00 00", s, upd, stable);
        end
        reinit(1'b0, 4'd3, 4'd3);
        do_start(2'b11, 2'b11);
        checks++;
        if (upd !== 2'b11 || s !== 2'b11) begin
            failures++;
            $display("FAIL div3_after_rst got upd=%b s=%b want 11 11", upd, s);
        end
    endtask

    task automatic test_trace();
        logic [1:0]  cur;
        logic [31:0] exp_tc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reinit(1'b0, 4'd1, 4'd1);
        cur = 2'b00;
        for (int k = 0; k < 5; k++) begin
            cur = ~cur;
            do_start(2'b11, cur);
        end
        reinit(1'b0, 4'd1, 4'd1);
        cur = 2'b00;
        for (int k = 0; k < 3; k++) begin
            cur = ~cur;
            do_start(2'b11, cur);
        end
`ifdef GNR_NODE_TRACE_EN
        exp_tc = {16'd8, 16'd8};
`else
        exp_tc = 32'h0;
`endif
        checks++;
        if (trans_cnt !== exp_tc) begin
            failures++;
            $display("FAIL trace_cnt got %h want %h", trans_cnt, exp_tc);
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_div_coerce();
        test_reinit_vs_start();
        test_stable();
        test_rst_mid_divide();
        test_trace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
